// File: rtl/axi_to_reg_burst_if.sv
// axi_ifc: AXI3-style bus bundle (GP port subset) between PS master and register bridge
interface axi_ifc;
  logic [11:0] awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [11:0] arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [11:0] rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  modport master(output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
                        arid, araddr, arlen, arburst, arvalid, rready,
                 input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid);
  modport slave(input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
                       arid, araddr, arlen, arburst, arvalid, rready,
                output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_to_reg_burst.sv
// axi_to_reg_burst: AXI slave bridging INCR/FIXED bursts onto COUNT register files
module axi_to_reg_burst #(
  parameter int COUNT        = 8,
  parameter int R_ADDR_WIDTH = 2,
  parameter int SEL_LSB      = 20,
  parameter int SEL_WIDTH    = 3,
  parameter int RD_LATENCY   = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  axi_ifc.slave                       s,
  output logic [R_ADDR_WIDTH-1:0]     o_wreg,
  output logic [31:0]                 o_wdata,
  output logic [3:0]                  o_wstrb,
  output logic [COUNT-1:0]            o_wr,
  output logic [R_ADDR_WIDTH-1:0]     o_rreg,
  output logic [COUNT-1:0]            o_rd,
  input  logic [COUNT-1:0][31:0]      i_rdata
);
  localparam int LW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_ADDR, R_STROBE, R_WAIT, R_DATA} rstate_t;
  wstate_t r_wst, w_wnxt;
  rstate_t r_rst, w_rnxt;
  logic [11:0] r_wid, r_rid;
  logic [7:0] r_wlen, r_wcnt, r_rlen, r_rcnt;
  logic [SEL_WIDTH-1:0] r_wsel, r_rsel, w_awsel, w_arsel;
  logic [R_ADDR_WIDTH-1:0] r_wreg, r_rreg;
  logic [LW-1:0] r_rlat;
  logic r_wfix, r_wbad, r_wdec, r_wlerr, r_rfix, r_rbad, r_rdec;
  logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast;
  logic [1:0] r_bresp, r_rresp;
  logic [31:0] r_rdata, w_rsdata;
  logic w_aw, w_wbeat, w_wfin, w_wlerr, w_wen, w_ar, w_rfin, w_rhs, w_lat_done, w_ren, w_unused;
  assign w_awsel    = s.awaddr[SEL_LSB+:SEL_WIDTH];
  assign w_arsel    = s.araddr[SEL_LSB+:SEL_WIDTH];
  assign w_aw       = s.awvalid & r_awready;
  assign w_wbeat    = s.wvalid & r_wready;
  assign w_wfin     = r_wcnt == r_wlen;
  assign w_wlerr    = s.wlast != w_wfin;
  assign w_wen      = w_wbeat & ~r_wdec & ~r_wbad;
  assign w_ar       = s.arvalid & r_arready;
  assign w_rfin     = r_rcnt == r_rlen;
  assign w_rhs      = r_rvalid & s.rready;
  assign w_lat_done = r_rlat == LW'(RD_LATENCY - 1);
  assign w_ren      = (r_rst == R_STROBE) & ~r_rdec & ~r_rbad;
  assign w_unused   = ^{s.awaddr, s.araddr};
  assign s.awready  = r_awready;
  assign s.wready   = r_wready;
  assign s.bvalid   = r_bvalid;
  assign s.bresp    = r_bresp;
  assign s.bid      = r_wid;
  assign s.arready  = r_arready;
  assign s.rvalid   = r_rvalid;
  assign s.rlast    = r_rlast;
  assign s.rresp    = r_rresp;
  assign s.rdata    = r_rdata;
  assign s.rid      = r_rid;
  assign o_wreg     = r_wreg;
  assign o_rreg     = r_rreg;
  assign o_wdata    = r_wready ? s.wdata : '0;
  assign o_wstrb    = r_wready ? s.wstrb : '0;
  // next-state logic for both channel FSMs
  always_comb begin
    w_wnxt = (r_wst == W_ADDR) ? (w_aw ? W_DATA : W_ADDR) :
             (r_wst == W_DATA) ? ((w_wbeat && w_wfin) ? W_RESP : W_DATA) :
             ((r_bvalid && s.bready) ? W_ADDR : W_RESP);
    w_rnxt = (r_rst == R_ADDR)   ? (w_ar ? R_STROBE : R_ADDR) :
             (r_rst == R_STROBE) ? R_WAIT :
             (r_rst == R_WAIT)   ? (w_lat_done ? R_DATA : R_WAIT) :
             (w_rhs ? (w_rfin ? R_ADDR : R_STROBE) : R_DATA);
  end
  // per-file strobe decode and read-data mux; out-of-range selects match nothing
  always_comb begin
    o_wr = '0;
    o_rd = '0;
    w_rsdata = '0;
    for (int i = 0; i < COUNT; i++) begin
      o_wr[i] = w_wen && r_wsel == SEL_WIDTH'(i);
      o_rd[i] = w_ren && r_rsel == SEL_WIDTH'(i);
      if (r_rsel == SEL_WIDTH'(i)) w_rsdata = i_rdata[i];
    end
  end
  // state registers; handshake outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wst <= W_ADDR;
      r_rst <= R_ADDR;
      {r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast} <= '0;
    end else begin
      r_wst     <= w_wnxt;
      r_rst     <= w_rnxt;
      r_awready <= w_wnxt == W_ADDR;
      r_wready  <= w_wnxt == W_DATA;
      r_bvalid  <= w_wnxt == W_RESP;
      r_arready <= w_rnxt == R_ADDR;
      r_rvalid  <= w_rnxt == R_DATA;
      r_rlast   <= w_rnxt == R_DATA && w_rfin;
    end
  end
  // write burst context, index stepping and sticky response
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {r_wid, r_wlen, r_wcnt, r_wsel, r_wreg, r_wfix, r_wbad, r_wdec, r_wlerr, r_bresp} <= '0;
    end else begin
      if (w_aw) begin
        r_wid   <= s.awid;
        r_wlen  <= s.awlen;
        r_wcnt  <= '0;
        r_wfix  <= s.awburst != 2'b01;
        r_wbad  <= s.awburst[1];
        r_wdec  <= 32'(w_awsel) >= COUNT;
        r_wsel  <= w_awsel;
        r_wreg  <= s.awaddr[2+:R_ADDR_WIDTH];
        r_wlerr <= 1'b0;
      end
      if (w_wbeat) begin
        r_wcnt  <= r_wcnt + 8'd1;
        r_wreg  <= r_wfix ? r_wreg : r_wreg + R_ADDR_WIDTH'(1);
        r_wlerr <= r_wlerr | w_wlerr;
      end
      if (w_wbeat && w_wfin)
        r_bresp <= r_wdec ? 2'b11 : (r_wbad | r_wlerr | w_wlerr) ? 2'b10 : 2'b00;
    end
  end
  // read burst context; data is captured RD_LATENCY edges after the file first sees o_rd
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {r_rid, r_rlen, r_rcnt, r_rsel, r_rreg, r_rfix, r_rbad, r_rdec, r_rlat, r_rresp, r_rdata} <= '0;
    end else begin
      if (w_ar) begin
        r_rid  <= s.arid;
        r_rlen <= s.arlen;
        r_rcnt <= '0;
        r_rfix <= s.arburst != 2'b01;
        r_rbad <= s.arburst[1];
        r_rdec <= 32'(w_arsel) >= COUNT;
        r_rsel <= w_arsel;
        r_rreg <= s.araddr[2+:R_ADDR_WIDTH];
      end
      r_rlat <= (r_rst == R_WAIT) ? r_rlat + LW'(1) : '0;
      if (r_rst == R_WAIT && w_lat_done) begin
        r_rdata <= (r_rdec | r_rbad) ? '0 : w_rsdata;
        r_rresp <= r_rdec ? 2'b11 : r_rbad ? 2'b10 : 2'b00;
      end
      if (r_rst == R_DATA && w_rhs && !w_rfin) begin
        r_rcnt <= r_rcnt + 8'd1;
        r_rreg <= r_rfix ? r_rreg : r_rreg + R_ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_axi_to_reg_burst.sv
// tb_axi_to_reg_burst: directed vectors against the burst register bridge
module tb_axi_to_reg_burst;
  localparam int COUNT = 6;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  axi_ifc ifc();
  logic [RW-1:0] o_wreg, o_rreg;
  logic [31:0] o_wdata;
  logic [3:0] o_wstrb;
  logic [COUNT-1:0] o_wr, o_rd;
  logic [COUNT-1:0][31:0] i_rdata;
  axi_to_reg_burst #(.COUNT(COUNT)) dut (
    .clk(clk), .rstn(rstn), .s(ifc),
    .o_wreg(o_wreg), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wr(o_wr),
    .o_rreg(o_rreg), .o_rd(o_rd), .i_rdata(i_rdata)
  );
  // register files: file i returns 0x100*i + index one clock after the index is seen
  always @(posedge clk)
    for (int i = 0; i < COUNT; i++) i_rdata[i] <= 32'((i << 8) + int'(o_rreg));
  int wr_n = 0, rd_n = 0;
  logic [COUNT-1:0] wl_m [64];
  logic [RW-1:0]    wl_r [64];
  logic [3:0]       wl_s [64];
  logic [31:0]      wl_d [64];
  logic [COUNT-1:0] rl_m [64];
  logic [RW-1:0]    rl_r [64];
  // log every register-side strobe
  always @(posedge clk) begin
    if (o_wr != 0) begin
      wl_m[wr_n % 64] <= o_wr; wl_r[wr_n % 64] <= o_wreg;
      wl_s[wr_n % 64] <= o_wstrb; wl_d[wr_n % 64] <= o_wdata;
      wr_n <= wr_n + 1;
    end
    if (o_rd != 0) begin
      rl_m[rd_n % 64] <= o_rd; rl_r[rd_n % 64] <= o_rreg;
      rd_n <= rd_n + 1;
    end
  end
  int n_vec = 0, n_bad = 0;
  logic [31:0] g_d [16];
  logic [1:0]  g_r [16];
  logic        g_l [16];
  logic [11:0] g_id [16];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic axw(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                     input int lastpos, input bit gaps, input int bdly,
                     output logic [1:0] resp, output logic [11:0] bid,
                     output bit aw_seen, output bit bv_hold);
    int k;
    ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len; ifc.awburst = burst; ifc.awvalid = 1'b1;
    k = 0; while (!ifc.awready && k < 20) begin tick; k++; end
    if (k >= 20) chk("aw_timeout", 0, 1);
    tick; ifc.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps) begin ifc.wvalid = 1'b0; tick; tick; end
      ifc.wdata = d0 + 32'(b); ifc.wstrb = strb; ifc.wlast = (b == lastpos); ifc.wvalid = 1'b1;
      k = 0; while (!ifc.wready && k < 20) begin tick; k++; end
      if (k >= 20) chk("w_timeout", 0, 1);
      tick;
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    k = 0; while (!ifc.bvalid && k < 20) begin tick; k++; end
    if (k >= 20) chk("b_timeout", 0, 1);
    aw_seen = 0; bv_hold = 1;
    for (int i = 0; i < bdly; i++) begin aw_seen |= ifc.awready; bv_hold &= ifc.bvalid; tick; end
    resp = ifc.bresp; bid = ifc.bid; ifc.bready = 1'b1;
    tick; ifc.bready = 1'b0;
    chk("b_done", {ifc.bvalid, ifc.awready}, 2'b01);
  endtask
  task automatic axr(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input logic [1:0] burst, output int lat);
    int k;
    ifc.arid = id; ifc.araddr = addr; ifc.arlen = len; ifc.arburst = burst; ifc.arvalid = 1'b1;
    k = 0; while (!ifc.arready && k < 20) begin tick; k++; end
    if (k >= 20) chk("ar_timeout", 0, 1);
    tick; ifc.arvalid = 1'b0;
    lat = 0; while (!ifc.rvalid && lat < 20) begin tick; lat++; end
    for (int b = 0; b <= int'(len); b++) begin
      k = 0; while (!ifc.rvalid && k < 20) begin tick; k++; end
      if (k >= 20) chk("r_timeout", 0, 1);
      g_d[b % 16] = ifc.rdata; g_r[b % 16] = ifc.rresp; g_l[b % 16] = ifc.rlast; g_id[b % 16] = ifc.rid;
      ifc.rready = 1'b1; tick; ifc.rready = 1'b0;
    end
    chk("r_done", {ifc.rvalid, ifc.arready}, 2'b01);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] resp;
    logic [11:0] bid;
    bit aw_seen, bv_hold, seen;
    int lat, w0, r0;
    logic [31:0] e_incr [4];
    logic [RW-1:0] e_idx [4];
    e_incr = '{32'h102, 32'h103, 32'h100, 32'h101};
    e_idx = '{2'd2, 2'd3, 2'd0, 2'd1};
    {ifc.awid, ifc.awaddr, ifc.awlen, ifc.awburst, ifc.awvalid} = '0;
    {ifc.wdata, ifc.wstrb, ifc.wlast, ifc.wvalid, ifc.bready} = '0;
    {ifc.arid, ifc.araddr, ifc.arlen, ifc.arburst, ifc.arvalid, ifc.rready} = '0;
    tick; tick; tick;
    chk("rst_hs", {ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid, ifc.rlast}, 0);
    chk("rst_strobes", {o_wr, o_rd, o_wreg, o_rreg}, 0);
    chk("rst_resp", {ifc.bresp, ifc.rresp, ifc.bid, ifc.rid}, 0);
    rstn = 1'b1; tick;
    chk("rel_ready", {ifc.awready, ifc.arready}, 2'b11);
    // single write to file 3, index 2
    w0 = wr_n;
    axw(12'h0A5, 32'h0030_0008, 8'd0, 2'b01, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, bid, aw_seen, bv_hold);
    chk("sw_count", wr_n - w0, 1);
    chk("sw_mask", wl_m[w0 % 64], 6'b001000);
    chk("sw_reg", wl_r[w0 % 64], 2);
    chk("sw_strb", wl_s[w0 % 64], 4'hF);
    chk("sw_data", wl_d[w0 % 64], 32'hDEADBEEF);
    chk("sw_bresp", resp, 2'b00);
    chk("sw_bid", bid, 12'h0A5);
    // select 7 out of range for COUNT=6
    w0 = wr_n;
    axw(12'h011, 32'h0070_0000, 8'd0, 2'b01, 32'h1, 4'hF, 0, 0, 0, resp, bid, aw_seen, bv_hold);
    chk("dec_w_count", wr_n - w0, 0);
    chk("dec_bresp", resp, 2'b11);
    r0 = rd_n;
    axr(12'h022, 32'h0070_0000, 8'd1, 2'b01, lat);
    chk("dec_r_count", rd_n - r0, 0);
    chk("dec_r_lat", lat, 3);
    chk("dec_rdata", {g_d[0], g_d[1]}, 64'h0);
    chk("dec_rresp", {g_r[0], g_r[1]}, 4'b1111);
    chk("dec_rlast", {g_l[0], g_l[1]}, 2'b01);
    // wlast asserted early: writes proceed, response flags it
    w0 = wr_n;
    axw(12'h033, 32'h0000_0000, 8'd2, 2'b01, 32'hA0, 4'h1, 1, 0, 0, resp, bid, aw_seen, bv_hold);
    chk("wl_count", wr_n - w0, 3);
    chk("wl_regs", {wl_r[w0 % 64], wl_r[(w0 + 1) % 64], wl_r[(w0 + 2) % 64]}, 6'b00_01_10);
    chk("wl_bresp", resp, 2'b10);
    r0 = rd_n;
    axr(12'h044, 32'h0010_0000, 8'd0, 2'b10, lat);
    chk("wrap_r_count", rd_n - r0, 0);
    chk("wrap_rdata", g_d[0], 0);
    chk("wrap_rresp", g_r[0], 2'b10);
    // FIXED burst of 4 with data gaps and a slow bready
    w0 = wr_n;
    axw(12'h055, 32'h0020_0004, 8'd3, 2'b00, 32'h50, 4'h3, 3, 1, 5, resp, bid, aw_seen, bv_hold);
    chk("fx_count", wr_n - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fx_reg", wl_r[(w0 + i) % 64], 1);
      chk("fx_mask", wl_m[(w0 + i) % 64], 6'b000100);
    end
    chk("fx_data", wl_d[(w0 + 3) % 64], 32'h53);
    chk("fx_bresp", resp, 2'b00);
    chk("fx_bhold", bv_hold, 1);
    chk("fx_no_aw", aw_seen, 0);
    // INCR read of 4 beats from file 1 starting at index 2
    r0 = rd_n;
    axr(12'h005, 32'h0010_0008, 8'd3, 2'b01, lat);
    chk("ir_lat", lat, 3);
    chk("ir_count", rd_n - r0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("ir_rreg", rl_r[(r0 + i) % 64], e_idx[i]);
      chk("ir_mask", rl_m[(r0 + i) % 64], 6'b000010);
      chk("ir_rdata", g_d[i], e_incr[i]);
      chk("ir_rid", g_id[i], 12'h005);
    end
    chk("ir_rlast", {g_l[0], g_l[1], g_l[2], g_l[3]}, 4'b0001);
    chk("ir_rresp", {g_r[0], g_r[1], g_r[2], g_r[3]}, 8'h00);
    // reset with a write in W_DATA and a read in R_WAIT
    ifc.awid = 12'h009; ifc.awaddr = 32'h0050_000C; ifc.awlen = 8'd1; ifc.awburst = 2'b01; ifc.awvalid = 1'b1;
    ifc.arid = 12'h007; ifc.araddr = 32'h0040_0008; ifc.arlen = 8'd1; ifc.arburst = 2'b01; ifc.arvalid = 1'b1;
    tick; ifc.awvalid = 1'b0; ifc.arvalid = 1'b0;
    tick;
    chk("mid_state", {ifc.wready, ifc.rvalid, o_wreg, o_rreg}, {1'b1, 1'b0, 2'd3, 2'd2});
    rstn = 1'b0; tick;
    chk("mr_hs", {ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid, ifc.rlast}, 0);
    chk("mr_strobes", {o_wr, o_rd, o_wreg, o_rreg, o_wstrb}, 0);
    chk("mr_ids", {ifc.bid, ifc.rid, ifc.bresp, ifc.rresp}, 0);
    chk("mr_rdata", {ifc.rdata, o_wdata}, 0);
    rstn = 1'b1; tick;
    chk("mr_rel", {ifc.awready, ifc.arready, ifc.bvalid, ifc.rvalid}, 4'b1100);
    seen = 0;
    for (int i = 0; i < 6; i++) begin seen |= ifc.rvalid | ifc.bvalid; tick; end
    chk("mr_stale", seen, 0);
    w0 = wr_n;
    axw(12'h003, 32'h0040_000C, 8'd0, 2'b01, 32'h12345678, 4'h5, 0, 0, 0, resp, bid, aw_seen, bv_hold);
    chk("pr_w", {wl_m[w0 % 64], wl_r[w0 % 64], wl_s[w0 % 64], wl_d[w0 % 64]},
        {6'b010000, 2'd3, 4'h5, 32'h12345678});
    chk("pr_b", {resp, bid, 32'(wr_n - w0)}, {2'b00, 12'h003, 32'd1});
    axr(12'h002, 32'h0040_000C, 8'd0, 2'b01, lat);
    chk("pr_r", {g_d[0], g_r[0], g_l[0], g_id[0]}, {32'h403, 2'b00, 1'b1, 12'h002});
    chk("pr_lat", lat, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
